program_out_capture: RTL and testbench

- Receive-side monitor for the 16-bit program_out bus of Multi_Cycle_Computer.
- Samples the bus every clock and detects value changes.
- Pushes each change, tagged with a cycle timestamp, into a small show-ahead FIFO.
- The FIFO is drained by a valid/ready reader (bench or debug UART), so result sequences are checked without waveform inspection.

---
 rtl/program_out_capture_if.sv | 26 ++
 rtl/program_out_capture.sv | 171 +++++++++++++++++
 tb/tb_program_out_capture.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/program_out_capture_if.sv
// Reader-side handshake for program_out_capture: show-ahead head entry plus valid/ready.
// Ports: rd_valid (FIFO non-empty), rd_ready (reader takes head), rd_data / rd_ts (head entry).
// master = capture block driving the head, slave = reader draining it.
interface program_out_capture_if #(
  parameter int DATA_W = 16,
  parameter int TS_W   = 16
);
  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;
  logic [TS_W-1:0]   rd_ts;

  modport master (
    output rd_valid,
    output rd_data,
    output rd_ts,
    input  rd_ready
  );

  modport slave (
    input  rd_valid,
    input  rd_data,
    input  rd_ts,
    output rd_ready
  );
endinterface

// File: rtl/program_out_capture.sv
// Purpose: watch program_out every clock, queue each value change with its cycle timestamp.
// Latency: a change sampled on edge N is at the FIFO head (rd_valid=1) right after edge N.
// Backpressure: reader stalls via rd_ready; when full, new changes are dropped and counted.
// Ports: clock/reset (async, active-high), program_out/capture_en (observed bus + gate),
//        rd (head entry valid/ready), count (occupancy), overflow/drop_count/clear_overflow.

// Generic show-ahead FIFO. A push is accepted when not full, or when full with a pop
// in the same cycle (the freed head slot is the one being written).
module poc_fifo #(
  parameter int W      = 32,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop_rdy,
  output logic          accept,
  output logic          vld,
  output logic [W-1:0]  head_dat,
  output logic [ADDR_W:0] count
);
  typedef enum logic {IDLE, ACTIVE} state_t;

  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [W-1:0]      mem [DEPTH];
  logic              pop;

  // State register: IDLE <-> ACTIVE tracks whether count is zero.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_comb begin
    pop      = 1'b0;
    accept   = 1'b0;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    state_d  = state_q;

    // Only ACTIVE has a head to pop; rd_ready while IDLE is ignored.
    pop    = (state_q == ACTIVE) && pop_rdy;
    accept = push && ((count_q != FULL_CNT) || pop);

    if (accept) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)    rd_ptr_d = rd_ptr_q + PTR_ONE;

    case ({accept, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    case (state_q)
      IDLE:    state_d = (count_d != '0) ? ACTIVE : IDLE;
      ACTIVE:  state_d = (count_d == '0) ? IDLE : ACTIVE;
      default: state_d = IDLE;
    endcase
  end

  // Storage needs no reset: contents are only observed while vld=1.
  always_ff @(posedge clock) begin
    if (accept) mem[wr_ptr_q] <= push_dat;
  end

  assign vld      = (state_q == ACTIVE);
  assign head_dat = mem[rd_ptr_q];
  assign count    = count_q;
endmodule

module program_out_capture #(
  parameter int DATA_W = 16,
  parameter int TS_W   = 16,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_W-1:0]    program_out,
  input  logic                 capture_en,
  program_out_capture_if.master rd,
  output logic [ADDR_W:0]      count,
  output logic                 overflow,
  input  logic                 clear_overflow,
  output logic [7:0]           drop_count
);
  localparam logic [TS_W-1:0] TS_ONE = TS_W'(1);

  logic [TS_W-1:0]        ts_q;
  logic [DATA_W-1:0]      prev_q;
  logic                   prev_valid_q;
  logic                   overflow_q;
  logic [7:0]             drop_q;
  logic                   change;
  logic                   push_req;
  logic                   accept;
  logic                   drop;
  logic [TS_W+DATA_W-1:0] head;

  // The first edge after reset always counts as a change so the initial bus value is logged.
  assign change   = !prev_valid_q || (program_out != prev_q);
  assign push_req = change && capture_en;
  assign drop     = push_req && !accept;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ts_q         <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
    end else begin
      ts_q         <= ts_q + TS_ONE;
      prev_q       <= program_out;
      prev_valid_q <= 1'b1;
    end
  end

  // A drop in the same cycle as clear_overflow wins and restarts the count at 1.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else if (drop) begin
      overflow_q <= 1'b1;
      if (clear_overflow)      drop_q <= 8'd1;
      else if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
    end else if (clear_overflow) begin
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end
  end

  poc_fifo #(
    .W      (TS_W + DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clock    (clock),
    .reset    (reset),
    .push     (push_req),
    .push_dat ({ts_q, program_out}),
    .pop_rdy  (rd.rd_ready),
    .accept   (accept),
    .vld      (rd.rd_valid),
    .head_dat (head),
    .count    (count)
  );

  assign rd.rd_ts    = head[DATA_W +: TS_W];
  assign rd.rd_data  = head[DATA_W-1:0];
  assign overflow    = overflow_q;
  assign drop_count  = drop_q;
endmodule

// File: tb/tb_program_out_capture.sv
// Directed bench for program_out_capture: vector table for the basic change/pop flow,
// hand sequences for overflow, full push+pop, saturation, async reset and capture gating.
module tb_program_out_capture;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] program_out = '0;
  logic        capture_en = 1'b1;
  logic        clear_overflow = 1'b0;
  logic [3:0]  count;
  logic        overflow;
  logic [7:0]  drop_count;

  int n_checks = 0;
  int n_pass   = 0;

  program_out_capture_if #(.DATA_W(16), .TS_W(16)) rd_if ();

  program_out_capture dut (
    .clock          (clock),
    .reset          (reset),
    .program_out    (program_out),
    .capture_en     (capture_en),
    .rd             (rd_if.master),
    .count          (count),
    .overflow       (overflow),
    .clear_overflow (clear_overflow),
    .drop_count     (drop_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] bus;
    logic        cap;
    logic        rdy;
    logic        clr;
    logic        ev;
    logic [3:0]  ecnt;
    logic [15:0] edat;
    logic [15:0] ets;
    logic        eovf;
    logic [7:0]  edrop;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [15:0] bus, logic cap, logic rdy, logic ev,
                              logic [3:0] ecnt, logic [15:0] edat, logic [15:0] ets);
    vec_t v;
    v.bus = bus; v.cap = cap; v.rdy = rdy; v.clr = 1'b0;
    v.ev = ev; v.ecnt = ecnt; v.edat = edat; v.ets = ets;
    v.eovf = 1'b0; v.edrop = 8'd0;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_head(string name, logic [15:0] dat, logic [15:0] ts);
    check({name, ".valid"}, 32'(rd_if.rd_valid), 32'd1);
    check({name, ".data"},  32'(rd_if.rd_data),  32'(dat));
    check({name, ".ts"},    32'(rd_if.rd_ts),    32'(ts));
  endtask

  // Holds reset across two edges with the given bus value, checks cleared state, releases.
  task automatic do_reset(logic [15:0] bus);
    reset = 1'b1;
    program_out = bus;
    capture_en = 1'b1;
    rd_if.rd_ready = 1'b0;
    clear_overflow = 1'b0;
    tick();
    tick();
    check("rst.count",    32'(count),          32'd0);
    check("rst.valid",    32'(rd_if.rd_valid), 32'd0);
    check("rst.overflow", 32'(overflow),       32'd0);
    check("rst.drop",     32'(drop_count),     32'd0);
    reset = 1'b0;
  endtask

  initial begin
    rd_if.rd_ready = 1'b0;

    // Edge k after reset release uses ts = k-1.
    for (int i = 0; i < 10; i++) vecs.push_back(mk(16'h0000, 1, 0, 1, 4'd1, 16'h0000, 16'd0));
    vecs.push_back(mk(16'h0005, 1, 0, 1, 4'd2, 16'h0000, 16'd0));   // ts 10 pushed
    vecs.push_back(mk(16'h0005, 1, 0, 1, 4'd2, 16'h0000, 16'd0));
    vecs.push_back(mk(16'h000A, 1, 0, 1, 4'd3, 16'h0000, 16'd0));   // ts 12
    vecs.push_back(mk(16'h000A, 1, 0, 1, 4'd3, 16'h0000, 16'd0));
    vecs.push_back(mk(16'h0003, 1, 0, 1, 4'd4, 16'h0000, 16'd0));   // ts 14
    vecs.push_back(mk(16'h0003, 1, 1, 1, 4'd3, 16'h0005, 16'd10));
    vecs.push_back(mk(16'h0003, 1, 1, 1, 4'd2, 16'h000A, 16'd12));
    vecs.push_back(mk(16'h0003, 1, 1, 1, 4'd1, 16'h0003, 16'd14));
    vecs.push_back(mk(16'h0003, 1, 1, 0, 4'd0, 16'h0000, 16'd0));
    vecs.push_back(mk(16'h0003, 1, 1, 0, 4'd0, 16'h0000, 16'd0));   // ready while empty
    vecs.push_back(mk(16'h0007, 1, 1, 1, 4'd1, 16'h0007, 16'd20));  // empty -> valid next edge
    vecs.push_back(mk(16'h0007, 1, 1, 0, 4'd0, 16'h0000, 16'd0));
    vecs.push_back(mk(16'h0009, 0, 0, 0, 4'd0, 16'h0000, 16'd0));   // change while gated
    vecs.push_back(mk(16'h0009, 1, 0, 0, 4'd0, 16'h0000, 16'd0));   // not deferred

    do_reset(16'h0000);
    foreach (vecs[i]) begin
      program_out    = vecs[i].bus;
      capture_en     = vecs[i].cap;
      rd_if.rd_ready = vecs[i].rdy;
      clear_overflow = vecs[i].clr;
      tick();
      check($sformatf("vec%0d.count", i), 32'(count),          32'(vecs[i].ecnt));
      check($sformatf("vec%0d.valid", i), 32'(rd_if.rd_valid), 32'(vecs[i].ev));
      check($sformatf("vec%0d.ovf", i),   32'(overflow),       32'(vecs[i].eovf));
      check($sformatf("vec%0d.drop", i),  32'(drop_count),     32'(vecs[i].edrop));
      if (vecs[i].ev) check_head($sformatf("vec%0d", i), vecs[i].edat, vecs[i].ets);
    end

    // Overflow: 12 changes into an 8-deep FIFO, then clear.
    do_reset(16'h0000);
    for (int i = 0; i < 12; i++) begin
      program_out = 16'h0100 + 16'(i);
      tick();
    end
    check("ovf.count", 32'(count),      32'd8);
    check("ovf.flag",  32'(overflow),   32'd1);
    check("ovf.drop",  32'(drop_count), 32'd4);
    check_head("ovf.head", 16'h0100, 16'd0);
    clear_overflow = 1'b1;
    tick();
    clear_overflow = 1'b0;
    check("clr.flag",  32'(overflow),   32'd0);
    check("clr.drop",  32'(drop_count), 32'd0);
    check("clr.count", 32'(count),      32'd8);

    // Full FIFO, change plus pop in the same cycle (ts 13).
    program_out = 16'hBEEF;
    rd_if.rd_ready = 1'b1;
    tick();
    check("fullpp.count", 32'(count),      32'd8);
    check("fullpp.ovf",   32'(overflow),   32'd0);
    check("fullpp.drop",  32'(drop_count), 32'd0);
    check_head("fullpp.head", 16'h0101, 16'd1);
    for (int i = 0; i < 7; i++) tick();
    rd_if.rd_ready = 1'b0;
    check("drain.count", 32'(count), 32'd1);
    check_head("drain.head", 16'hBEEF, 16'd13);

    // drop_count saturation, then drop coinciding with clear.
    do_reset(16'h0000);
    for (int i = 0; i < 308; i++) begin
      program_out = 16'h0200 + 16'(i);
      tick();
      if (i == 261) check("sat.drop254", 32'(drop_count), 32'd254);
    end
    check("sat.drop", 32'(drop_count), 32'd255);
    check("sat.ovf",  32'(overflow),   32'd1);
    check("sat.count", 32'(count),     32'd8);
    clear_overflow = 1'b1;
    program_out = 16'h7777;
    tick();
    check("clrdrop.ovf",  32'(overflow),   32'd1);
    check("clrdrop.drop", 32'(drop_count), 32'd1);
    tick();
    clear_overflow = 1'b0;
    check("clr2.ovf",  32'(overflow),   32'd0);
    check("clr2.drop", 32'(drop_count), 32'd0);

    // Async reset mid-cycle with 5 entries pending.
    do_reset(16'h0000);
    for (int i = 0; i < 5; i++) begin
      program_out = 16'h0300 + 16'(i);
      tick();
    end
    check("ar.pre_count", 32'(count), 32'd5);
    program_out = 16'h0ABC;
    #2 reset = 1'b1;
    #1;
    check("ar.count", 32'(count),          32'd0);
    check("ar.valid", 32'(rd_if.rd_valid), 32'd0);
    #2 reset = 1'b0;
    tick();
    check("ar.recount", 32'(count), 32'd1);
    check_head("ar.recap", 16'h0ABC, 16'd0);

    // capture_en gating: 1111 -> (gated) 2222 -> steady -> 3333.
    do_reset(16'h1111);
    tick();
    check_head("gate.first", 16'h1111, 16'd0);
    capture_en = 1'b0;
    program_out = 16'h2222;
    tick();
    check("gate.off", 32'(count), 32'd1);
    capture_en = 1'b1;
    tick();
    check("gate.on_steady", 32'(count), 32'd1);
    program_out = 16'h3333;
    tick();
    check("gate.change", 32'(count), 32'd2);
    rd_if.rd_ready = 1'b1;
    tick();
    rd_if.rd_ready = 1'b0;
    check("gate.pop_count", 32'(count), 32'd1);
    check_head("gate.second", 16'h3333, 16'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
